// File: rtl/i2s_tx_serializer_if.sv
// FIFO read port between the audio sample FIFO and the I2S transmitter.
// The FIFO is first-word-fall-through: fifo_out is valid whenever fifo_empty=0,
// and a one-clock fifo_rd_en pops the head word.
interface i2s_tx_serializer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] fifo_out;
  logic             fifo_empty;
  logic             fifo_rd_en;

  // Reader side (the serializer): consumes the head word and issues pops
  modport master (
    input  fifo_out,
    input  fifo_empty,
    output fifo_rd_en
  );

  // FIFO side: presents the head word and accepts pops
  modport slave (
    output fifo_out,
    output fifo_empty,
    input  fifo_rd_en
  );
endinterface

// File: rtl/i2s_tx_serializer.sv
// Philips-format I2S transmitter.
// Pops left/right 16-bit samples from a FWFT FIFO and shifts them out MSB-first
// on SDATA, generating BCLK and WS from the system clock. An empty FIFO at a
// load slot sends a silent word and bumps a saturating underrun counter.
module i2s_tx_serializer #(
  parameter int CLK_DIV = 4,
  parameter int WIDTH   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  i2s_tx_serializer_if.master fifo_if,
  output logic                bclk,
  output logic                ws,
  output logic                sdata,
  output logic                busy,
  output logic                underrun,
  output logic [7:0]          underrun_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Slot numbering: left word occupies slots 0..15, right word 16..31.
  localparam logic [4:0] SLOT_ENTRY = 5'd30;
  localparam logic [4:0] SLOT_LAST  = 5'd31;
  localparam logic [4:0] SLOT_LEFT  = 5'd0;
  localparam logic [4:0] SLOT_RIGHT = 5'd16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [DIV_W-1:0] r_div;
  logic             r_bclk;
  logic             r_ws;
  logic             r_sdata;
  logic             r_busy;
  logic             r_rd_en;
  logic             r_underrun;
  logic [7:0]       r_underrun_cnt;
  logic [4:0]       r_slot;
  logic [WIDTH-1:0] r_shift;

  logic             w_start;
  logic             w_tick;
  logic             w_fall;
  logic             w_stop;
  logic             w_load;
  logic [4:0]       w_slot_next;

  // WS is high for the right channel and switches one slot ahead of the MSB.
  function automatic logic ws_for_slot(input logic [4:0] slot);
    return (slot >= 5'd15) && (slot <= 5'd30);
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and slot-event decode; a frame only ends at its final slot.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_tick       = 1'b0;
    w_fall       = 1'b0;
    w_stop       = 1'b0;
    w_load       = 1'b0;
    w_slot_next  = r_slot;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_start      = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_div == DIV_LAST) begin
          w_tick = 1'b1;
          if (r_bclk) begin
            w_fall = 1'b1;
            if ((r_slot == SLOT_LAST) && !en) begin
              w_stop       = 1'b1;
              w_state_next = ST_IDLE;
            end else begin
              w_slot_next = (r_slot == SLOT_LAST) ? SLOT_LEFT : (r_slot + 5'd1);
              w_load      = (w_slot_next == SLOT_LEFT) || (w_slot_next == SLOT_RIGHT);
            end
          end else begin
            w_fall = 1'b0;
          end
        end else begin
          w_tick = 1'b0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Bit clock divider, slot counter, shift register and FIFO pop/underrun handling
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div          <= '0;
      r_bclk         <= 1'b0;
      r_ws           <= 1'b1;
      r_sdata        <= 1'b0;
      r_busy         <= 1'b0;
      r_rd_en        <= 1'b0;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= 8'd0;
      r_slot         <= SLOT_ENTRY;
      r_shift        <= '0;
    end else begin
      r_rd_en    <= 1'b0;
      r_underrun <= 1'b0;
      if (w_start) begin
        // Shift register is cleared so the two pre-roll slots are silent.
        r_div   <= '0;
        r_bclk  <= 1'b0;
        r_slot  <= SLOT_ENTRY;
        r_ws    <= 1'b1;
        r_shift <= '0;
        r_sdata <= 1'b0;
        r_busy  <= 1'b1;
      end else if (r_state == ST_RUN) begin
        if (w_tick) begin
          r_div  <= '0;
          r_bclk <= ~r_bclk;
        end else begin
          r_div <= r_div + {{(DIV_W-1){1'b0}}, 1'b1};
        end
        if (w_stop) begin
          r_bclk  <= 1'b0;
          r_ws    <= 1'b1;
          r_sdata <= 1'b0;
          r_busy  <= 1'b0;
          r_slot  <= SLOT_ENTRY;
        end else if (w_fall) begin
          r_slot <= w_slot_next;
          r_ws   <= ws_for_slot(w_slot_next);
          if (w_load) begin
            if (!fifo_if.fifo_empty) begin
              r_shift <= fifo_if.fifo_out;
              r_sdata <= fifo_if.fifo_out[WIDTH-1];
              r_rd_en <= 1'b1;
            end else begin
              r_shift    <= '0;
              r_sdata    <= 1'b0;
              r_underrun <= 1'b1;
              if (r_underrun_cnt != 8'hFF) begin
                r_underrun_cnt <= r_underrun_cnt + 8'd1;
              end else begin
                r_underrun_cnt <= r_underrun_cnt;
              end
            end
          end else begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            r_sdata <= r_shift[WIDTH-2];
          end
        end else begin
          r_slot <= r_slot;
        end
      end else begin
        r_div <= r_div;
      end
    end
  end

  assign bclk               = r_bclk;
  assign ws                 = r_ws;
  assign sdata              = r_sdata;
  assign busy               = r_busy;
  assign underrun           = r_underrun;
  assign underrun_cnt       = r_underrun_cnt;
  assign fifo_if.fifo_rd_en = r_rd_en;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench for i2s_tx_serializer: a FWFT FIFO model feeds the DUT,
// expected serial bits are queued when words are pushed and popped on each
// BCLK rise; slot position is tracked from observed BCLK edges.
module tb_i2s_tx_serializer;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       bclk, ws, sdata, busy, underrun;
  logic [7:0] underrun_cnt;

  i2s_tx_serializer_if #(.WIDTH(16)) fifo_if ();

  i2s_tx_serializer #(.CLK_DIV(CLK_DIV), .WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .fifo_if      (fifo_if.master),
    .bclk         (bclk),
    .ws           (ws),
    .sdata        (sdata),
    .busy         (busy),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [15:0] fq[$];
  bit          eq[$];
  logic        prev_bclk = 1'b0;
  logic        prev_busy = 1'b0;
  int          slot_m    = 30;
  bit          pre       = 1'b1;
  int          t_entry   = 0;
  int          last_rise = -1;
  int          n_pop     = 0;
  int          n_urun    = 0;
  int          pop_slot[$];
  int          pop_cyc[$];
  int          urun_cyc[$];
  int          snap;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ws_exp(input int s);
    return (s >= 15) && (s <= 30);
  endfunction

  task automatic fifo_sync();
    fifo_if.fifo_empty = (fq.size() == 0);
    fifo_if.fifo_out   = (fq.size() > 0) ? fq[0] : 16'h0000;
  endtask

  task automatic push_word(input logic [15:0] w);
    fq.push_back(w);
    for (int b = 15; b >= 0; b--) eq.push_back(w[b]);
    fifo_sync();
  endtask

  task automatic push_silence(input int nbits);
    for (int k = 0; k < nbits; k++) eq.push_back(1'b0);
  endtask

  // One clock of monitoring, sampled on the falling clk edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (busy && !prev_busy) begin
      slot_m = 30; pre = 1'b1; t_entry = cyc; last_rise = -1;
    end
    if (!bclk && prev_bclk && busy) begin
      slot_m = (slot_m == 31) ? 0 : slot_m + 1;
      if (slot_m == 0) pre = 1'b0;
    end
    if (bclk && !prev_bclk) begin
      if (last_rise < 0) check("first_rise_latency", cyc - t_entry, CLK_DIV);
      else               check("bclk_period", cyc - last_rise, 2 * CLK_DIV);
      last_rise = cyc;
      check("ws_slot", ws, ws_exp(slot_m));
      if (pre) begin
        check("preroll_sdata", sdata, 1'b0);
      end else begin
        check("sb_has_entry", eq.size() > 0, 1'b1);
        if (eq.size() > 0) check("sdata_bit", sdata, eq.pop_front());
      end
    end
    if (fifo_if.fifo_rd_en) begin
      n_pop++;
      pop_slot.push_back(slot_m);
      pop_cyc.push_back(cyc);
      check("pop_nonempty", fq.size() > 0, 1'b1);
      check("pop_slot", (slot_m == 0) || (slot_m == 16), 1'b1);
      if (fq.size() > 0) void'(fq.pop_front());
    end
    if (underrun) begin
      n_urun++;
      urun_cyc.push_back(cyc);
      check("underrun_slot", (slot_m == 0) || (slot_m == 16), 1'b1);
    end
    prev_bclk = bclk;
    prev_busy = busy;
    fifo_sync();
  endtask

  task automatic run_to_slot(input int s, input string tag);
    for (int i = 0; i < 2000 && !(busy && !pre && slot_m == s); i++) step();
    check(tag, slot_m, s);
  endtask

  task automatic run_to_idle(input string tag);
    for (int i = 0; i < 2000 && busy; i++) step();
    check(tag, busy, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_bclk"}, bclk, 1'b0);
    check({tag, "_ws"}, ws, 1'b1);
    check({tag, "_sdata"}, sdata, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    fifo_sync();
    // Reset held with en=1 and a loaded FIFO: nothing moves
    rst = 1'b0;
    en  = 1'b1;
    push_word(16'hA5F0);
    push_word(16'h1234);
    repeat (6) step();
    check_idle_outputs("reset");
    check("reset_rd_en", fifo_if.fifo_rd_en, 1'b0);
    check("reset_underrun", underrun, 1'b0);
    check("reset_cnt", underrun_cnt, 8'd0);
    check("reset_no_pop", n_pop, 0);

    // Release: one frame of A5F0/1234, en dropped at slot 5
    rst = 1'b1;
    run_to_slot(5, "reach_slot5");
    en = 1'b0;
    run_to_idle("stop_after_frame");
    check("stop_last_slot", slot_m, 31);
    check_idle_outputs("stop");
    check("frame1_pops", n_pop, 2);
    check("frame1_pop0_slot", (pop_slot.size() > 0) ? pop_slot[0] : -1, 0);
    check("frame1_pop1_slot", (pop_slot.size() > 1) ? pop_slot[1] : -1, 16);
    check("frame1_lr_spacing", (pop_cyc.size() > 1) ? pop_cyc[1] - pop_cyc[0] : -1, 128);
    check("frame1_sb_drained", eq.size(), 0);
    check("frame1_no_underrun", underrun_cnt, 8'd0);

    // Idle with data waiting must not pop
    push_word(16'h8001);
    push_word(16'h7FFE);
    repeat (40) step();
    check("idle_no_pop", n_pop, 2);
    check_idle_outputs("idle");

    // Re-enable: fresh frame from slot 30 with a new left load
    pop_slot.delete();
    en = 1'b1;
    run_to_slot(5, "rerun_slot5");
    check("rerun_left_pop", pop_slot.size(), 1);
    check("rerun_left_slot", (pop_slot.size() > 0) ? pop_slot[0] : -1, 0);
    en = 1'b0;
    run_to_idle("rerun_stop");
    check("rerun_pops", n_pop, 4);
    check("rerun_sb_drained", eq.size(), 0);

    // Empty FIFO for two frames: silence and four underruns
    snap = n_pop;
    urun_cyc.delete();
    push_silence(64);
    en = 1'b1;
    for (int i = 0; i < 2000 && n_urun < 3; i++) step();
    check("empty_third_underrun", n_urun, 3);
    en = 1'b0;
    run_to_idle("empty_stop");
    check("empty_underruns", n_urun, 4);
    check("empty_cnt", underrun_cnt, 8'd4);
    check("empty_no_pop", n_pop, snap);
    check("frame_period", (urun_cyc.size() > 2) ? urun_cyc[2] - urun_cyc[0] : -1, 256);
    check("empty_sb_drained", eq.size(), 0);

    // Drive the total to 300 underruns: counter must saturate at 255
    push_silence(296 * 16);
    en = 1'b1;
    for (int i = 0; i < 45000 && n_urun < 300; i++) step();
    check("sat_underruns_reached", n_urun, 300);
    en = 1'b0;
    run_to_idle("sat_stop");
    check("sat_cnt", underrun_cnt, 8'hFF);
    check("sat_no_pop", n_pop, snap);
    check("sat_sb_drained", eq.size(), 0);

    // Asynchronous reset in the middle of slot 20
    push_word(16'hC3C3);
    push_word(16'h5A5A);
    en = 1'b1;
    run_to_slot(20, "reach_slot20");
    step();
    step();
    rst = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst_rd_en", fifo_if.fifo_rd_en, 1'b0);
    check("async_rst_underrun", underrun, 1'b0);
    check("async_rst_cnt", underrun_cnt, 8'd0);
    eq.delete();
    snap = n_pop;
    repeat (60) step();
    check("async_rst_no_pop", n_pop, snap);
    check("async_rst_hold_bclk", bclk, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Downstream consumer of the audio sample FIFO in the I2S output path.
- Pops 16-bit samples from the FIFO, alternating left then right, and serializes them MSB-first onto a Philips-format I2S bus (BCLK, WS, SDATA) toward the DAC.
- Generates BCLK and WS from the system clock.
- On FIFO underrun, transmits silence and counts the event.

Parameters:
- CLK_DIV, 4, system-clock cycles per BCLK half-period (>=2); BCLK period = 2*CLK_DIV clk.
- WIDTH, 16, sample width; frame = 2*WIDTH BCLK slots (fixed 16 in this release, 32-slot frame).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- en  input  1  1 = run/continue streaming; 0 = stop at end of current frame.
- fifo_out  input  16  FIFO head word (FIFO is first-word-fall-through: valid whenever fifo_empty=0).
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  one-clk pop strobe to FIFO.
- bclk  output  1  I2S bit clock.
- ws  output  1  I2S word select, 0 = left, 1 = right.
- sdata  output  1  I2S serial data, changes only on BCLK falling edges.
- busy  output  1  1 while in RUN.
- underrun  output  1  one-clk pulse when a slot loads silence due to empty FIFO.
- underrun_cnt  output  8  saturating count of underrun events.

Behaviour:
- Reset (rst=0, async): state=IDLE; bclk=0, ws=1, sdata=0, fifo_rd_en=0, busy=0, underrun=0, underrun_cnt=0, div counter=0, slot s=30, shift register=0.
- States: IDLE, RUN.
- IDLE -> RUN: when en=1. Entry sets div=0, bclk=0, s=30, ws=1.
- RUN, divider: div counts 0..CLK_DIV-1. At div=CLK_DIV-1: toggle bclk, div=0.
  - First toggle after entry is rising: first BCLK rise occurs CLK_DIV clk after the RUN entry edge.
- Rising toggle (bclk 0->1): no other action; the receiver samples here.
- Falling toggle (bclk 1->0) = slot event. s_next = (s==31) ? 0 : s+1, and:
  - ws = 1 for s_next in 15..30, 0 for s_next in 31 and 0..14. WS leads the MSB by one slot.
  - s_next=0: load left word. s_next=16: load right word.
  - Load: if fifo_empty=0, shift <= fifo_out and fifo_rd_en=1 for that single clk. If fifo_empty=1, shift <= 0, no pop, underrun=1 for that clk, underrun_cnt increments and saturates at 255.
  - sdata = shift[15] after load. On non-load slot events, shift left by 1 and sdata = new MSB. Slot s carries left bit 15-s for s<16, right bit 31-s otherwise.
- Stop: on the slot event where s=31 and en=0, the event goes to IDLE instead of s=0:
  - bclk=0, ws=1, sdata=0, busy=0, no pop.
  - en low mid-frame never truncates a frame.
- en toggling during RUN affects only the s=31 decision.
- fifo_rd_en is asserted at most once per 16 slots and never when fifo_empty=1.
- No popping in IDLE.
- Async reset mid-frame aborts immediately with no further pops; a partial frame on the bus is acceptable.
- fifo_empty rising between loads has no effect until the next load event.

Test Plan:
- Reset with CLK_DIV=4: hold rst=0, en=1 -> bclk=0, ws=1, sdata=0, fifo_rd_en=0, underrun_cnt=0. Release -> first bclk rise 4 clk after RUN entry; bclk period 8 clk; frame 256 clk.
- FIFO preloaded with 0xA5F0 (L) and 0x1234 (R), en=1:
  - exactly one fifo_rd_en pulse at slot 0 and one at slot 16;
  - sdata sampled on bclk rises over slots 0..15 = 1010010111110000, over slots 16..31 = 0001001000110100;
  - ws=0 from slot 31 through 14, ws=1 from slot 15 through 30.
- Empty FIFO, en=1 for 2 frames: sdata all 0, fifo_rd_en never asserted, 4 underrun pulses, underrun_cnt=4.
- Force 300 underruns -> underrun_cnt saturates at 255, no wrap.
- Drop en at slot 5 of a frame -> frame completes through slot 31 including the right-word pop, then IDLE with busy=0, bclk=0, ws=1. Re-assert en -> new frame starts at s=30 with a fresh left load.
- Assert rst=0 mid-slot 20 -> outputs reach reset values asynchronously in the same cycle, no further fifo_rd_en, underrun_cnt=0.
